// File: rtl/seq_alu_if.sv
// Request/response bundle between issue, seq_alu and writeback.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             CF;
  logic             ZF;
  logic             SF;
  logic             ERR;

  modport master (
    output flush, in_valid, ALUControl, SrcA, SrcB, out_ready,
    input  in_ready, out_valid, ALUResult, CF, ZF, SF, ERR
  );

  modport slave (
    input  flush, in_valid, ALUControl, SrcA, SrcB, out_ready,
    output in_ready, out_valid, ALUResult, CF, ZF, SF, ERR
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith ops, iterative MUL/DIVU/REMU.
// One operation in flight; result held in DONE until out_ready.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2;
  localparam logic [3:0] OP_ADD = 4'b0000, OP_SLL = 4'b0001, OP_SUB = 4'b0010,
                         OP_XOR = 4'b0100, OP_SRL = 4'b0101, OP_OR  = 4'b0110,
                         OP_AND = 4'b0111, OP_MUL = 4'b1000, OP_DIVU = 4'b1001,
                         OP_REMU = 4'b1010, OP_SRA = 4'b1011;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand (MUL) or divisor (DIV/REM)
  logic [WIDTH-1:0] hi_q, hi_d;       // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;       // multiplier -> product low / dividend -> quotient
  logic [WIDTH-1:0] res_q, res_d;
  logic             cf_q, cf_d, zf_q, zf_d, sf_q, sf_d, err_q, err_d;

  logic [CNT_W-2:0] sh;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_cf, sc_err;
  logic [WIDTH:0]   mul_sum, div_r, div_s;
  logic             div_ge;
  logic [WIDTH-1:0] hi_it, lo_it;
  logic             fin, fin_cf, fin_err;
  logic [WIDTH-1:0] fin_res;

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.ALUResult = res_q;
  assign bus.CF        = cf_q;
  assign bus.ZF        = zf_q;
  assign bus.SF        = sf_q;
  assign bus.ERR       = err_q;

  // Single-cycle datapath, evaluated straight off the request operands
  always_comb begin
    sh     = bus.SrcB[CNT_W-2:0];
    add_w  = {1'b0, bus.SrcA} + {1'b0, bus.SrcB};
    sc_res = '0;
    sc_cf  = 1'b0;
    sc_err = 1'b0;
    case (bus.ALUControl)
      OP_ADD:  begin sc_res = add_w[WIDTH-1:0]; sc_cf = add_w[WIDTH]; end
      OP_SLL:  sc_res = bus.SrcA << sh;
      OP_SUB:  begin sc_res = bus.SrcA - bus.SrcB; sc_cf = (bus.SrcA < bus.SrcB); end
      OP_XOR:  sc_res = bus.SrcA ^ bus.SrcB;
      OP_SRL:  sc_res = bus.SrcA >> sh;
      OP_OR:   sc_res = bus.SrcA | bus.SrcB;
      OP_AND:  sc_res = bus.SrcA & bus.SrcB;
      OP_SRA:  sc_res = WIDTH'($signed(bus.SrcA) >>> sh);
      OP_MUL, OP_DIVU, OP_REMU: sc_res = '0;
      default: sc_err = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring shift-subtract divide
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_r   = {hi_q, lo_q[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, opnd_q});
    div_s   = div_ge ? (div_r - {1'b0, opnd_q}) : div_r;
    if (op_q == OP_MUL) begin
      hi_it = mul_sum[WIDTH:1];
      lo_it = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else begin
      hi_it = div_s[WIDTH-1:0];
      lo_it = {lo_q[WIDTH-2:0], div_ge};
    end
  end

  // Control FSM and result capture; flush has the last word
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    cf_d    = cf_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    err_d   = err_q;
    fin     = 1'b0;
    fin_res = '0;
    fin_cf  = 1'b0;
    fin_err = 1'b0;
    case (state_q)
      S_IDLE: if (bus.in_valid) begin
        op_d = bus.ALUControl;
        case (bus.ALUControl)
          OP_MUL: begin
            opnd_d  = bus.SrcA;
            hi_d    = '0;
            lo_d    = bus.SrcB;
            cnt_d   = CNT_W'(WIDTH);
            state_d = S_BUSY;
          end
          OP_DIVU, OP_REMU: begin
            if (bus.SrcB == '0) begin
              // divide by zero resolves at acceptance
              fin     = 1'b1;
              fin_res = (bus.ALUControl == OP_DIVU) ? '1 : bus.SrcA;
              fin_cf  = 1'b1;
              state_d = S_DONE;
            end else begin
              opnd_d  = bus.SrcB;
              hi_d    = '0;
              lo_d    = bus.SrcA;
              cnt_d   = CNT_W'(WIDTH);
              state_d = S_BUSY;
            end
          end
          default: begin
            fin     = 1'b1;
            fin_res = sc_res;
            fin_cf  = sc_cf;
            fin_err = sc_err;
            state_d = S_DONE;
          end
        endcase
      end
      S_BUSY: begin
        hi_d  = hi_it;
        lo_d  = lo_it;
        cnt_d = cnt_q - CNT_W'(1);
        // last iteration registers straight into the result
        if (cnt_q == CNT_W'(1)) begin
          fin     = 1'b1;
          fin_res = (op_q == OP_REMU) ? hi_it : lo_it;
          fin_cf  = (op_q == OP_MUL) && (hi_it != '0);
          state_d = S_DONE;
        end
      end
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      res_d = fin_res;
      cf_d  = fin_cf;
      err_d = fin_err;
      zf_d  = (fin_res == '0);
      sf_d  = fin_res[WIDTH-1];
    end
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = '0;
      cf_d    = 1'b0;
      err_d   = 1'b0;
      sf_d    = 1'b0;
      zf_d    = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      cf_q    <= 1'b0;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      cf_q    <= cf_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      err_q   <= err_d;
    end
  end
endmodule
